pe_mac_seq: RTL and testbench
=============================

// Module: pe_mac_seq
// PURPOSE
//   Job-level sequencer wrapping one pe_core instance. It accepts a dot-product job (length, ReLU flag),
//   streams operand pairs into the PE via valid/ready, clears the accumulator beforehand and waits out
//   the PE pipeline. It then returns one W_ACC result via valid/ready. Sits between the array scheduler
//   and each PE.
// PARAMETERS
//   W_IN    8   operand width (a unsigned, b signed)
//   W_ACC   24  accumulator/result width
//   LEN_W   10  job length field width (max 2**LEN_W-1 beats)
//   PE_LAT  4   cycles from pe_en beat to updated pe_core results
// PORTS
//   clk        in   1      clock
//   reset      in   1      asynchronous, active-high reset
//   job_valid  in   1      job request
//   job_ready  out  1      high only in IDLE
//   job_len    in   LEN_W  number of operand beats
//   job_relu   in   1      1: ReLU on result, 0: raw
//   op_valid   in   1      operand pair valid
//   op_ready   out  1      high only in STREAM
//   op_a       in   W_IN   unsigned operand
//   op_b       in   W_IN   signed operand
//   res_valid  out  1      result valid, held until res_ready
//   res_ready  in   1      result accept
//   res_data   out  W_ACC  signed result
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   - Reset, asynchronous: state=IDLE, res_valid=0, res_data=0, busy=0, counters=0. Reset also goes
//     to the internal pe_core. Reset mid-job abandons the job; no result is produced.
//   - Job accept: job_valid&job_ready latches len_q=job_len and relu_q=job_relu.
//     - len!=0: go to CLEAR.
//     - len==0: go to DONE with res_data=0.
//   - CLEAR (1 cycle): reg_reset=1, pe_en=0, then STREAM. The PE clear has priority over accumulate,
//     so it must never share a cycle with a beat.
//   - STREAM: op_ready=1. Each op_valid&op_ready cycle drives pe_en=1, a=op_a, b=op_b to the PE
//     combinationally and increments beat_cnt.
//     - op_valid=0 inserts a bubble: pe_en=0, and the PE holds its state.
//     - On the beat where beat_cnt==len_q-1, go to DRAIN with drain_cnt=0.
//   - DRAIN: pe_en=0, drain_cnt increments; it lasts exactly PE_LAT cycles.
//     - On the last DRAIN cycle, res_data<=pe_results, then DONE.
//     - res_valid rises PE_LAT+1 cycles after the final beat's handshake cycle.
//   - DONE: res_valid=1, res_data stable. res_valid&res_ready goes to IDLE in the same edge:
//     res_valid=0, res_data held.
//   - mode_sel=relu_q for the whole job (CLEAR through DRAIN). It must not change while PE beats are
//     in flight.
//   - IDLE drives PE controls (pe_en, reg_reset) to 0; job_ready is asserted only in IDLE.
//   - Arithmetic: 9x8 signed product, sign-extended and wrapped at W_ACC, all inside pe_core.
//     No saturation. Overflow wraps.
//   - Simultaneous events:
//     - job_valid during a non-IDLE state is ignored (job_ready=0).
//     - op_valid outside STREAM is ignored.
// STRUCTURE
//   - pe_pkg holds:
//     - typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} seq_state_t
//     - localparam PE_LAT=4
//     - default widths W_IN/W_ACC
//   - One sub-module: u_pe (pe_core). The FSM, beat/drain counters and result register live here.
// TESTING
//   - len=3, relu=0, pairs (10,2),(3,-4),(255,-128) -> res_data=-32632;
//     res_valid 5 cycles after last beat.
//   - Same pairs, relu=1 -> res_data=0; pairs (100,100),(1,1) relu=1 -> 10001.
//   - op_valid toggled 1-0-1-0, len=4 of (1,1) -> res_data=4; beat count matches handshakes only.
//   - Back-to-back jobs (2,3)x2 then (1,-1)x1 -> 12 then -1, with no carry-over from the first job.
//   - res_ready low 10 cycles -> res_valid and res_data stable, job_ready=0; len=0 job -> res_data=0.
//   - reset pulsed mid-STREAM -> all outputs 0 next cycle, IDLE.
//     A fresh len=1 (7,-3) job -> res_data=-21.

Source files
------------

// File: rtl/pe_mac_seq_pkg.sv
// Shared types, widths and helpers for the PE job sequencer and its pe_core.
package pe_mac_seq_pkg;

  localparam int W_IN   = 8;
  localparam int W_ACC  = 24;
  localparam int LEN_W  = 10;
  localparam int PE_LAT = 4;
  localparam int W_PROD = 2 * W_IN + 1;
  localparam int DRN_W  = $clog2(PE_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  // Clamp negative values to zero when ReLU is enabled.
  function automatic logic [W_ACC-1:0] relu_f(input logic [W_ACC-1:0] v, input logic en);
    logic [W_ACC-1:0] r;
    if (en && v[W_ACC-1]) begin
      r = {W_ACC{1'b0}};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac_seq_if.sv
// Job, operand and result handshakes between the array scheduler and one PE sequencer.
interface pe_mac_seq_if;
  import pe_mac_seq_pkg::*;

  logic             job_valid;
  logic             job_ready;
  logic [LEN_W-1:0] job_len;
  logic             job_relu;
  logic             op_valid;
  logic             op_ready;
  logic [W_IN-1:0]  op_a;
  logic [W_IN-1:0]  op_b;
  logic             res_valid;
  logic             res_ready;
  logic [W_ACC-1:0] res_data;
  logic             busy;

  modport master (
    output job_valid, job_len, job_relu, op_valid, op_a, op_b, res_ready,
    input  job_ready, op_ready, res_valid, res_data, busy
  );

  modport slave (
    input  job_valid, job_len, job_relu, op_valid, op_a, op_b, res_ready,
    output job_ready, op_ready, res_valid, res_data, busy
  );

endinterface

// File: rtl/pe_mac_seq_core.sv
// pe_core: 4-stage multiply-accumulate PE (operand reg, product, accumulate, ReLU output).
module pe_core
  import pe_mac_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_reset,
  input  logic             pe_en,
  input  logic             mode_sel,
  input  logic [W_IN-1:0]  a,
  input  logic [W_IN-1:0]  b,
  output logic [W_ACC-1:0] pe_results
);

  logic              s1_vld_q, s1_vld_d;
  logic [W_IN-1:0]   s1_a_q, s1_a_d;
  logic [W_IN-1:0]   s1_b_q, s1_b_d;
  logic              s2_vld_q, s2_vld_d;
  logic [W_PROD-1:0] s2_prod_q, s2_prod_d;
  logic [W_ACC-1:0]  acc_q, acc_d;
  logic [W_ACC-1:0]  res_q, res_d;
  logic [W_PROD-1:0] a_ext_s, b_ext_s;

  // Pipeline next-state; a clear wipes every stage so nothing stale survives into a job.
  always_comb begin
    a_ext_s   = {{(W_PROD-W_IN){1'b0}}, s1_a_q};
    b_ext_s   = {{(W_PROD-W_IN){s1_b_q[W_IN-1]}}, s1_b_q};
    s1_vld_d  = pe_en;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s2_vld_d  = s1_vld_q;
    s2_prod_d = s2_prod_q;
    acc_d     = acc_q;
    res_d     = relu_f(acc_q, mode_sel);
    if (pe_en) begin
      s1_a_d = a;
      s1_b_d = b;
    end else begin
      s1_a_d = s1_a_q;
    end
    if (s1_vld_q) begin
      s2_prod_d = a_ext_s * b_ext_s;
    end else begin
      s2_prod_d = s2_prod_q;
    end
    if (s2_vld_q) begin
      acc_d = acc_q + {{(W_ACC-W_PROD){s2_prod_q[W_PROD-1]}}, s2_prod_q};
    end else begin
      acc_d = acc_q;
    end
    if (reg_reset) begin
      s1_vld_d  = 1'b0;
      s2_vld_d  = 1'b0;
      s2_prod_d = {W_PROD{1'b0}};
      acc_d     = {W_ACC{1'b0}};
      res_d     = {W_ACC{1'b0}};
    end else begin
      s1_b_d = s1_b_d;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= {W_IN{1'b0}};
      s1_b_q    <= {W_IN{1'b0}};
      s2_vld_q  <= 1'b0;
      s2_prod_q <= {W_PROD{1'b0}};
      acc_q     <= {W_ACC{1'b0}};
      res_q     <= {W_ACC{1'b0}};
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s2_vld_q  <= s2_vld_d;
      s2_prod_q <= s2_prod_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
    end
  end

  assign pe_results = res_q;

endmodule

// File: rtl/pe_mac_seq.sv
// Job-level sequencer: accepts a dot-product job, streams beats into pe_core, drains, returns result.
module pe_mac_seq
  import pe_mac_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  pe_mac_seq_if.slave  bus
);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             relu_q, relu_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [W_ACC-1:0] res_data_q, res_data_d;
  logic             pe_en_s;
  logic             reg_reset_s;
  logic [W_ACC-1:0] pe_results_s;

  pe_core u_pe (
    .clk        (clk),
    .reset      (reset),
    .reg_reset  (reg_reset_s),
    .pe_en      (pe_en_s),
    .mode_sel   (relu_q),
    .a          (bus.op_a),
    .b          (bus.op_b),
    .pe_results (pe_results_s)
  );

  // Next-state and PE control decode.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    relu_d      = relu_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pe_en_s     = 1'b0;
    reg_reset_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          len_d       = bus.job_len;
          relu_d      = bus.job_relu;
          beat_cnt_d  = {LEN_W{1'b0}};
          drain_cnt_d = {DRN_W{1'b0}};
          if (bus.job_len == {LEN_W{1'b0}}) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = {W_ACC{1'b0}};
          end else begin
            state_d = CLEAR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        reg_reset_s = 1'b1;
        state_d     = STREAM;
      end
      STREAM: begin
        if (bus.op_valid) begin
          pe_en_s    = 1'b1;
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (beat_cnt_q == len_q - LEN_W'(1)) begin
            state_d     = DRAIN;
            drain_cnt_d = {DRN_W{1'b0}};
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRN_W'(1);
        if (drain_cnt_q == DRN_W'(PE_LAT - 1)) begin
          res_data_d  = pe_results_s;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer state, counters and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= {LEN_W{1'b0}};
      relu_q      <= 1'b0;
      beat_cnt_q  <= {LEN_W{1'b0}};
      drain_cnt_q <= {DRN_W{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {W_ACC{1'b0}};
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      relu_q      <= relu_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.job_ready = (state_q == IDLE);
  assign bus.op_ready  = (state_q == STREAM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_pe_mac_seq.sv
// Scoreboard bench for pe_mac_seq: expected results queued at job issue, compared at result.
module tb_pe_mac_seq;
  import pe_mac_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pe_mac_seq_if bus ();

  pe_mac_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int last_res;
  logic [W_ACC-1:0] exp_q[$];
  logic [W_IN-1:0]  a_arr [0:511];
  logic [W_IN-1:0]  b_arr [0:511];

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W_ACC-1:0] model(input int len, input bit relu);
    logic [W_ACC-1:0] acc;
    int p;
    acc = '0;
    for (int i = 0; i < len; i++) begin
      p   = int'(a_arr[i]) * int'($signed(b_arr[i]));
      acc = acc + W_ACC'(p);
    end
    if (relu && acc[W_ACC-1]) acc = '0;
    return acc;
  endfunction

  function automatic int sx(input logic [W_ACC-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic set_pairs(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) begin
      a_arr[i] = W_IN'(a);
      b_arr[i] = W_IN'(b);
    end
  endtask

  task automatic start_job(input int len, input bit relu, input bit push);
    int t;
    t = 0;
    bus.job_len   = LEN_W'(len);
    bus.job_relu  = relu;
    bus.job_valid = 1'b1;
    @(negedge clk);
    while (!bus.job_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("job_ready_seen", int'(bus.job_ready), 1);
    @(posedge clk);
    #1;
    bus.job_valid = 1'b0;
    if (push) exp_q.push_back(model(len, relu));
  endtask

  task automatic stream(input int len, input bit bubbles);
    int i, t;
    bit gap, hs;
    i = 0; t = 0; gap = 1'b0;
    while (i < len && t < 4 * len + 50) begin
      bus.op_valid = !(bubbles && gap);
      bus.op_a     = a_arr[i];
      bus.op_b     = b_arr[i];
      @(negedge clk);
      hs = bus.op_valid && bus.op_ready;
      @(posedge clk);
      #1;
      t++;
      if (hs) begin
        i++;
        gap = 1'b1;
      end else begin
        gap = 1'b0;
      end
    end
    bus.op_valid = 1'b0;
    check_val("beats_sent", i, len);
  endtask

  task automatic collect(input string tag, input int exp_lat, input int hold);
    int k;
    logic [W_ACC-1:0] e;
    k = 1;
    @(negedge clk);
    while (!bus.res_valid && k < 60) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check_val({tag, "_latency"}, k, exp_lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    last_res = sx(bus.res_data);
    check_val(tag, last_res, sx(e));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("hold_valid", int'(bus.res_valid), 1);
      check_val("hold_data", sx(bus.res_data), sx(e));
      check_val("hold_job_ready", int'(bus.job_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_valid_drop"}, int'(bus.res_valid), 0);
    check_val({tag, "_idle"}, int'(bus.job_ready), 1);
    check_val({tag, "_data_held"}, sx(bus.res_data), sx(e));
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string tag, input int len, input bit relu, input bit bubbles,
                         input int hold);
    start_job(len, relu, 1'b1);
    if (len > 0) begin
      stream(len, bubbles);
      collect(tag, PE_LAT + 1, hold);
    end else begin
      collect(tag, 1, hold);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_len   = '0;
    bus.job_relu  = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_res_valid", int'(bus.res_valid), 0);
    check_val("rst_res_data", sx(bus.res_data), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_job_ready", int'(bus.job_ready), 1);
    check_val("rst_op_ready", int'(bus.op_ready), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    a_arr[0] = 8'd10;  b_arr[0] = 8'd2;
    a_arr[1] = 8'd3;   b_arr[1] = W_IN'(-4);
    a_arr[2] = 8'd255; b_arr[2] = W_IN'(-128);
    run_job("mix_raw", 3, 1'b0, 1'b0, 0);
    check_val("mix_raw_spec", last_res, -32632);
    run_job("mix_relu", 3, 1'b1, 1'b0, 0);
    check_val("mix_relu_spec", last_res, 0);

    a_arr[0] = 8'd100; b_arr[0] = 8'd100;
    a_arr[1] = 8'd1;   b_arr[1] = 8'd1;
    run_job("pos_relu", 2, 1'b1, 1'b0, 0);
    check_val("pos_relu_spec", last_res, 10001);

    set_pairs(4, 1, 1);
    run_job("bubbles", 4, 1'b0, 1'b1, 0);
    check_val("bubbles_spec", last_res, 4);

    set_pairs(2, 2, 3);
    run_job("b2b_first", 2, 1'b0, 1'b0, 0);
    check_val("b2b_first_spec", last_res, 12);
    set_pairs(1, 1, -1);
    run_job("b2b_second", 1, 1'b0, 1'b0, 0);
    check_val("b2b_second_spec", last_res, -1);

    set_pairs(1, 5, 6);
    run_job("hold", 1, 1'b0, 1'b0, 10);
    check_val("hold_spec", last_res, 30);
    run_job("len0", 0, 1'b0, 1'b0, 0);
    check_val("len0_spec", last_res, 0);

    set_pairs(260, 255, -128);
    run_job("wrap", 260, 1'b0, 1'b0, 0);
    check_val("wrap_spec", last_res, 8290816);

    set_pairs(4, 9, 9);
    start_job(4, 1'b0, 1'b0);
    stream(2, 1'b0);
    reset = 1'b1;
    #1;
    check_val("mid_rst_res_valid", int'(bus.res_valid), 0);
    check_val("mid_rst_res_data", sx(bus.res_data), 0);
    check_val("mid_rst_busy", int'(bus.busy), 0);
    check_val("mid_rst_op_ready", int'(bus.op_ready), 0);
    check_val("mid_rst_job_ready", int'(bus.job_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_idle", int'(bus.busy), 0);

    set_pairs(1, 7, -3);
    run_job("fresh", 1, 1'b0, 1'b0, 0);
    check_val("fresh_spec", last_res, -21);
    check_val("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
